reglk_access_ctrl: RTL and testbench

Access controller for the register-lock bank: the six 32-bit lock words (`reglk_mem`) and the debug-unlock state. It arbitrates read/write requests from the host bus and the JTAG debug port, enforces lock bits on every write, and runs the debug-unlock key check with a retry limit. It sits between the bus/debug front-ends and the peripherals that consume `reglk_mem_o`.

---
 rtl/reglk_access_ctrl.sv | 132 +++++++++++++
 tb/tb_reglk_access_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/reglk_access_ctrl.sv
// rtl/reglk_access_ctrl.sv - register-lock bank access controller with debug-unlock FSM
//
// Ports:
//   clk_i, rst_low                      clock (rising edge), asynchronous active-low reset
//   host_req_i/we_i/idx_i/wdata_i       host access request (held until host_gnt_o)
//   host_gnt_o, host_err_o              one-cycle grant pulse, access-denied flag
//   dbg_req_i/we_i/idx_i/wdata_i        debug-port access request
//   dbg_gnt_o, dbg_err_o                debug grant pulse, access-denied flag
//   rdata_o                             read data (old word on writes), valid with either grant
//   key_valid_i, key_i                  debug unlock key strobe and value
//   relock_i                            return debug state to LOCKED
//   reglk_mem_o                         packed lock words, word i at [i*DATA_W +: DATA_W]
//   jtag_unlocked_o, lockout_o          debug unlocked / permanent lockout
module reglk_access_ctrl #(
    parameter int          NUM_REGS   = 6,
    parameter int          DATA_W     = 32,
    parameter logic [31:0] UNLOCK_KEY = 32'hA5C3_0F1E,
    parameter int          MAX_TRIES  = 3
) (
    input  logic                         clk_i,
    input  logic                         rst_low,
    input  logic                         host_req_i,
    input  logic                         host_we_i,
    input  logic [2:0]                   host_idx_i,
    input  logic [DATA_W-1:0]            host_wdata_i,
    output logic                         host_gnt_o,
    output logic                         host_err_o,
    input  logic                         dbg_req_i,
    input  logic                         dbg_we_i,
    input  logic [2:0]                   dbg_idx_i,
    input  logic [DATA_W-1:0]            dbg_wdata_i,
    output logic                         dbg_gnt_o,
    output logic                         dbg_err_o,
    output logic [DATA_W-1:0]            rdata_o,
    input  logic                         key_valid_i,
    input  logic [31:0]                  key_i,
    input  logic                         relock_i,
    output logic [NUM_REGS*DATA_W-1:0]   reglk_mem_o,
    output logic                         jtag_unlocked_o,
    output logic                         lockout_o
);

    localparam int CNT_W = $clog2(MAX_TRIES + 1);

    typedef enum logic [1:0] {
        ST_LOCKED   = 2'd0,
        ST_UNLOCKED = 2'd1,
        ST_LOCKOUT  = 2'd2
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  fail_cnt;
    logic              ptr;            // 0 = host has priority, 1 = debug
    logic [DATA_W-1:0] mem [NUM_REGS];

    logic              host_elig, dbg_elig, sel_host, sel_dbg, sel_any;
    logic              acc_we, idx_ok, wr_allow, acc_err, do_write;
    logic [2:0]        acc_idx;
    logic [DATA_W-1:0] acc_wdata, cur_word;

    // A requester that is being granted this cycle is still holding req;
    // that level belongs to the access already served, so it is masked.
    always_comb begin
        host_elig = host_req_i && !host_gnt_o;
        dbg_elig  = dbg_req_i && !dbg_gnt_o;
        sel_host  = host_elig && (!dbg_elig || !ptr);
        sel_dbg   = dbg_elig && !sel_host;
        sel_any   = sel_host || sel_dbg;
        acc_we    = sel_host ? host_we_i    : dbg_we_i;
        acc_idx   = sel_host ? host_idx_i   : dbg_idx_i;
        acc_wdata = sel_host ? host_wdata_i : dbg_wdata_i;
        idx_ok    = 32'(acc_idx) < NUM_REGS;

        cur_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (acc_idx == 3'(i)) cur_word = mem[i];
        end

        // Host writes only unlocked words; debug writes anything but only
        // while the unlock FSM is (already) UNLOCKED.
        wr_allow = idx_ok && (sel_host ? !cur_word[0] : (state == ST_UNLOCKED));
        acc_err  = !idx_ok || (acc_we && !wr_allow);
        do_write = sel_any && acc_we && wr_allow;
    end

    always_ff @(posedge clk_i or negedge rst_low) begin
        if (!rst_low) begin
            state      <= ST_LOCKED;
            fail_cnt   <= '0;
            ptr        <= 1'b0;
            host_gnt_o <= 1'b0;
            host_err_o <= 1'b0;
            dbg_gnt_o  <= 1'b0;
            dbg_err_o  <= 1'b0;
            rdata_o    <= '0;
            for (int i = 0; i < NUM_REGS; i++) mem[i] <= DATA_W'(1);
        end else begin
            host_gnt_o <= sel_host;
            dbg_gnt_o  <= sel_dbg;
            host_err_o <= sel_host && acc_err;
            dbg_err_o  <= sel_dbg && acc_err;
            rdata_o    <= (sel_any && idx_ok) ? cur_word : '0;

            if (host_elig && dbg_elig) ptr <= ~ptr;

            for (int i = 0; i < NUM_REGS; i++) begin
                if (do_write && acc_idx == 3'(i)) mem[i] <= acc_wdata;
            end

            // relock has priority: a key in the same cycle is dropped entirely.
            if (relock_i) begin
                if (state == ST_UNLOCKED) state <= ST_LOCKED;
            end else if (key_valid_i && state == ST_LOCKED) begin
                if (key_i == UNLOCK_KEY) begin
                    state    <= ST_UNLOCKED;
                    fail_cnt <= '0;
                end else begin
                    fail_cnt <= fail_cnt + 1'b1;
                    if (fail_cnt == CNT_W'(MAX_TRIES - 1)) state <= ST_LOCKOUT;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_pack
        assign reglk_mem_o[g*DATA_W +: DATA_W] = mem[g];
    end

    assign jtag_unlocked_o = (state == ST_UNLOCKED);
    assign lockout_o       = (state == ST_LOCKOUT);

endmodule

// File: tb/tb_reglk_access_ctrl.sv
// tb/tb_reglk_access_ctrl.sv - scoreboard testbench for reglk_access_ctrl
module tb_reglk_access_ctrl;

    localparam logic [31:0] KEY = 32'hA5C3_0F1E;

    logic         clk = 1'b0;
    logic         rst_low = 1'b0;
    logic         host_req = 1'b0, host_we = 1'b0;
    logic [2:0]   host_idx = '0;
    logic [31:0]  host_wdata = '0;
    logic         host_gnt, host_err;
    logic         dbg_req = 1'b0, dbg_we = 1'b0;
    logic [2:0]   dbg_idx = '0;
    logic [31:0]  dbg_wdata = '0;
    logic         dbg_gnt, dbg_err;
    logic [31:0]  rdata;
    logic         key_valid = 1'b0;
    logic [31:0]  key = '0;
    logic         relock = 1'b0;
    logic [191:0] reglk_mem;
    logic         jtag_unlocked, lockout;

    int total = 0;
    int bad = 0;

    logic [32:0] host_q[$];
    logic [32:0] dbg_q[$];

    reglk_access_ctrl dut (
        .clk_i(clk), .rst_low(rst_low),
        .host_req_i(host_req), .host_we_i(host_we), .host_idx_i(host_idx),
        .host_wdata_i(host_wdata), .host_gnt_o(host_gnt), .host_err_o(host_err),
        .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_idx_i(dbg_idx),
        .dbg_wdata_i(dbg_wdata), .dbg_gnt_o(dbg_gnt), .dbg_err_o(dbg_err),
        .rdata_o(rdata), .key_valid_i(key_valid), .key_i(key), .relock_i(relock),
        .reglk_mem_o(reglk_mem), .jtag_unlocked_o(jtag_unlocked), .lockout_o(lockout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [191:0] pack(input logic [31:0] w0, w1, w2, w3, w4, w5);
        return {w5, w4, w3, w2, w1, w0};
    endfunction

    // Monitor: pops the expected {err, rdata} whenever a grant is presented.
    initial begin
        logic [32:0] e;
        forever begin
            @(negedge clk);
            if (host_gnt && dbg_gnt) chk("both_grants", 192'(2'b11), 192'(2'b00));
            if (host_gnt) begin
                if (host_q.size() == 0) chk("host_unexpected_gnt", 192'(1), 192'(0));
                else begin
                    e = host_q.pop_front();
                    chk("host_resp", 192'({host_err, rdata}), 192'(e));
                end
            end
            if (dbg_gnt) begin
                if (dbg_q.size() == 0) chk("dbg_unexpected_gnt", 192'(1), 192'(0));
                else begin
                    e = dbg_q.pop_front();
                    chk("dbg_resp", 192'({dbg_err, rdata}), 192'(e));
                end
            end
        end
    end

    task automatic host_acc(input logic we, input logic [2:0] idx, input logic [31:0] wd,
                            input logic exp_err, input logic [31:0] exp_rd);
        bit got = 0;
        @(posedge clk); #1;
        host_q.push_back({exp_err, exp_rd});
        host_req = 1'b1; host_we = we; host_idx = idx; host_wdata = wd;
        for (int n = 0; n < 20 && !got; n++) begin
            @(posedge clk); #1;
            if (host_gnt) got = 1;
        end
        host_req = 1'b0;
        if (!got) chk("host_gnt_timeout", 192'(0), 192'(1));
    endtask

    task automatic dbg_acc(input logic we, input logic [2:0] idx, input logic [31:0] wd,
                           input logic exp_err, input logic [31:0] exp_rd);
        bit got = 0;
        @(posedge clk); #1;
        dbg_q.push_back({exp_err, exp_rd});
        dbg_req = 1'b1; dbg_we = we; dbg_idx = idx; dbg_wdata = wd;
        for (int n = 0; n < 20 && !got; n++) begin
            @(posedge clk); #1;
            if (dbg_gnt) got = 1;
        end
        dbg_req = 1'b0;
        if (!got) chk("dbg_gnt_timeout", 192'(0), 192'(1));
    endtask

    // One-cycle key strobe (optionally with relock); state is visible on return.
    task automatic key_pulse(input logic [31:0] k, input logic rl);
        @(posedge clk); #1;
        key_valid = 1'b1; key = k; relock = rl;
        @(posedge clk); #1;
        key_valid = 1'b0; relock = 1'b0;
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_mem", reglk_mem, pack(1, 1, 1, 1, 1, 1));
        chk("rst_outs", 192'({host_gnt, host_err, dbg_gnt, dbg_err, jtag_unlocked, lockout}), 192'(0));
        chk("rst_rdata", 192'(rdata), 192'(0));
        @(posedge clk); #1 rst_low = 1'b1;

        // Reads of every word, then a denied host write to a locked word
        for (int i = 0; i < 6; i++) host_acc(1'b0, 3'(i), 32'h0, 1'b0, 32'h1);
        host_acc(1'b1, 3'd2, 32'h0, 1'b1, 32'h1);
        chk("host_denied_mem", reglk_mem, pack(1, 1, 1, 1, 1, 1));

        // Unlock, debug clears word 2, host then rewrites it
        key_pulse(KEY, 1'b0);
        chk("unlocked", 192'({jtag_unlocked, lockout}), 192'(2'b10));
        dbg_acc(1'b1, 3'd2, 32'h0, 1'b0, 32'h1);
        chk("dbg_write_mem", reglk_mem, pack(1, 1, 0, 1, 1, 1));
        host_acc(1'b1, 3'd2, 32'h5, 1'b0, 32'h0);
        chk("host_write_mem", reglk_mem, pack(1, 1, 5, 1, 1, 1));
        host_acc(1'b1, 3'd2, 32'h7, 1'b1, 32'h5);
        chk("host_relocked_mem", reglk_mem, pack(1, 1, 5, 1, 1, 1));

        // Out-of-range index from both ports
        host_acc(1'b1, 3'd6, 32'h0, 1'b1, 32'h0);
        dbg_acc(1'b1, 3'd6, 32'h0, 1'b1, 32'h0);
        dbg_acc(1'b0, 3'd7, 32'h0, 1'b1, 32'h0);
        chk("idx_oob_mem", reglk_mem, pack(1, 1, 5, 1, 1, 1));

        // Relock and correct key in the same cycle: relock wins
        key_pulse(KEY, 1'b1);
        chk("relock_wins", 192'({jtag_unlocked, lockout}), 192'(2'b00));

        // Both requesting continuously: host, debug, host, ...
        for (int i = 0; i < 4; i++) begin
            host_q.push_back({1'b0, 32'h1});
            dbg_q.push_back({1'b0, 32'h5});
        end
        @(posedge clk); #1;
        host_req = 1'b1; host_we = 1'b0; host_idx = 3'd0;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_idx = 3'd2;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            chk("alternate", 192'({host_gnt, dbg_gnt}), (c % 2 == 0) ? 192'(2'b10) : 192'(2'b01));
        end
        host_req = 1'b0; dbg_req = 1'b0;
        @(posedge clk); #1;
        chk("alt_idle", 192'({host_gnt, dbg_gnt}), 192'(0));

        // Wrong keys up to lockout; correct key then ignored
        key_pulse(32'h1234_5678, 1'b0);
        key_pulse(32'h0, 1'b0);
        chk("two_wrong", 192'({jtag_unlocked, lockout}), 192'(2'b00));
        key_pulse(32'hFFFF_FFFF, 1'b0);
        chk("lockout", 192'({jtag_unlocked, lockout}), 192'(2'b01));
        key_pulse(KEY, 1'b0);
        chk("lockout_sticky", 192'({jtag_unlocked, lockout}), 192'(2'b01));
        dbg_acc(1'b1, 3'd3, 32'h0, 1'b1, 32'h1);
        chk("lockout_mem", reglk_mem, pack(1, 1, 5, 1, 1, 1));

        // Reset asserted while a grant is being presented
        @(posedge clk); #1;
        host_req = 1'b1; host_we = 1'b0; host_idx = 3'd1;
        @(posedge clk); #1;
        rst_low = 1'b0;
        host_req = 1'b0;
        #1;
        chk("midrst_gnt", 192'({host_gnt, dbg_gnt, host_err}), 192'(0));
        chk("midrst_mem", reglk_mem, pack(1, 1, 1, 1, 1, 1));
        chk("midrst_state", 192'({jtag_unlocked, lockout, rdata}), 192'(0));
        host_q.delete();
        @(posedge clk); #1 rst_low = 1'b1;
        host_acc(1'b0, 3'd2, 32'h0, 1'b0, 32'h1);
        repeat (2) @(posedge clk);
        #1;
        chk("queues_drained", 192'(host_q.size() + dbg_q.size()), 192'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
